fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO, the next generation of the channel FIFO. Width, depth and flow-control thresholds are configurable. It adds true full/empty detection, an occupancy count, overflow/underflow protection, and a hysteretic pause/continue flow-control state machine. It sits between a producer and a consumer on the same clock, carrying a data word plus a per-entry valid tag.

## Interface
Parameters:
- BUS_SIZE, 10: data word width in bits.
- ADDR_WIDTH, 3: pointer width; DEPTH = 1 << ADDR_WIDTH entries.
- ALMOST_FULL_TH, 6: occupancy at or above which almost_full is set and pause is raised.
- ALMOST_EMPTY_TH, 2: occupancy at or below which almost_empty is set and pause is released. Legal only if 0 < ALMOST_EMPTY_TH < ALMOST_FULL_TH <= DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  write request.
- pop  in  1  read request.
- valid  in  1  tag stored alongside data_in.
- data_in  in  BUS_SIZE  write data.
- data_out  out  BUS_SIZE  registered read data.
- valid_out  out  1  tag of the word just read.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- empty, full, almost_empty, almost_full  out  1 each  status flags.
- pause  out  1  flow-control stop to the producer.
- continua  out  1  always ~pause.
- err_overflow, err_underflow  out  1 each  sticky error flags (see Configuration).

## Operation
- Accepted push: push && (!full || pop). Accepted pop: pop && !empty.
- On an accepted push: mem[wr_ptr] <= {valid, data_in}; wr_ptr increments modulo DEPTH (natural wrap DEPTH-1 -> 0).
- On an accepted pop: {valid_out, data_out} <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
- count rules:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when both are accepted, or when neither is.
- Push and pop in the same cycle:
  - Not empty: both accepted; this includes the full case, where the slot freed by the read makes room.
  - Empty: push accepted; pop ignored (no bypass) and counts as an underflow.
- Push while full without pop: ignored. Memory, wr_ptr and count are unchanged. Counts as an overflow.
- Pop while empty: ignored. data_out holds its value; valid_out = 0.
- Flags, derived from the registered count:
  - empty = (count == 0)
  - full = (count == DEPTH)
  - almost_full = (count >= ALMOST_FULL_TH)
  - almost_empty = (count <= ALMOST_EMPTY_TH)
- Flow-control state machine, states FLOW_GO and FLOW_PAUSE:
  - FLOW_GO -> FLOW_PAUSE when the next count >= ALMOST_FULL_TH.
  - FLOW_PAUSE -> FLOW_GO when the next count <= ALMOST_EMPTY_TH.
  - Otherwise the state holds.
  - pause = (state == FLOW_PAUSE).
- Memory contents are not cleared on pop or on reset.

## Timing
- Reset values:
  - wr_ptr = rd_ptr = count = 0; data_out = 0; valid_out = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - state = FLOW_GO, so pause = 0 and continua = 1.
  - err_overflow = err_underflow = 0.
- Reset has priority over push and pop in the same cycle. Reset mid-stream discards all contents at that edge.
- Read latency is 1 cycle: data_out and valid_out update at the edge that accepts the pop.
- valid_out is a single-cycle pulse. It is 0 in any cycle not preceded by an accepted pop.
- Status flags and pause reflect the state after each edge. A push at edge N is visible in count and the flags from edge N onward, with no combinational path from push or pop.
- Throughput is one push and one pop per cycle sustained.

## Configuration
- Macro: FIFO_PARAM_ERR_EN.
- When defined:
  - err_overflow sets on any push while full without pop.
  - err_underflow sets on any pop while empty.
  - Both flags are sticky until reset.
- When undefined: both outputs are tied to 0 and the error registers are not built. Ignore-on-full and ignore-on-empty behaviour is unchanged.

## Structure
- Shared include fifo_pkg.vh holds:
  - the default parameter values;
  - the FLOW_GO = 1'b0 and FLOW_PAUSE = 1'b1 state encodings;
  - a DEPTH-from-ADDR_WIDTH macro.
- One sub-module, fifo_ram: a simple dual-port array with a synchronous write and a registered synchronous read, (BUS_SIZE+1) bits wide, DEPTH deep.
- Pointers, count, flags and the flow-control state machine live in fifo_param.

## Test plan
All scenarios use BUS_SIZE=10, ADDR_WIDTH=3, ALMOST_FULL_TH=6, ALMOST_EMPTY_TH=2.
- Reset, then pop one cycle -> empty=1, count=0, valid_out=0, data_out=0, err_underflow=1 (with macro).
- Push 0x001..0x008 with valid=1 -> count=8, full=1; pause set after the 6th push. A 9th push of 0x3FF is ignored: count stays 8 and err_overflow=1.
- Pop 8 times -> data_out = 0x001..0x008 in order, each one cycle after its pop. pause stays 1 until count reaches 2, then continua=1.
- Push 5, pop 5, repeated 3 times -> pointers wrap past 7; data stays in order and count returns to 0.
- Full FIFO with push and pop together -> both accepted, count stays 8, new word written into the freed slot. Empty FIFO with push and pop together -> count=1, valid_out=0.
- Push with valid alternating 1,0 -> valid_out follows 1,0 on readback. Reset asserted while count=4 -> count=0 and pause=0 on the next cycle.

Source files
------------

// File: rtl/fifo_param_pkg.sv
// Shared definitions for the parametrised FIFO: default parameter values,
// flow-control state encoding and the depth-from-pointer-width helper.
package fifo_param_pkg;

  localparam int unsigned BUS_SIZE_DEF        = 10;
  localparam int unsigned ADDR_WIDTH_DEF      = 3;
  localparam int unsigned ALMOST_FULL_TH_DEF  = 6;
  localparam int unsigned ALMOST_EMPTY_TH_DEF = 2;

  // Flow-control state: GO lets the producer run, PAUSE asks it to stop.
  typedef enum logic {
    FLOW_GO    = 1'b0,
    FLOW_PAUSE = 1'b1
  } flow_state_e;

  // Number of entries addressed by a pointer of the given width.
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array for the FIFO.
// Synchronous write; registered synchronous read (read-before-write on the
// same address, so a pop of a full FIFO sees the old word).
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high, clears the read register only
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write word
//   i_rd_en    read strobe, loads o_rd_data at the edge
//   i_rd_addr  read address
//   o_rd_data  registered read word (holds when i_rd_en is low)
module fifo_ram #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Storage array; contents are never cleared.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, status flags,
// overflow/underflow protection and hysteretic pause/continue flow control.
// Optional sticky error flags are built only when FIFO_PARAM_ERR_EN is
// defined; otherwise err_overflow/err_underflow are tied low.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   push, pop        write / read requests
//   valid, data_in   tag and data stored on an accepted push
//   data_out         registered read data, holds between pops
//   valid_out        tag of the word read at the previous edge (1-cycle pulse)
//   count            occupancy 0..DEPTH
//   empty, full, almost_empty, almost_full   status flags
//   pause, continua  flow control to the producer (continua = ~pause)
//   err_overflow, err_underflow              sticky error flags
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int unsigned BUS_SIZE        = BUS_SIZE_DEF,
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int unsigned ALMOST_FULL_TH  = ALMOST_FULL_TH_DEF,
  parameter int unsigned ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                valid,
  input  logic [BUS_SIZE-1:0] data_in,
  output logic [BUS_SIZE-1:0] data_out,
  output logic                valid_out,
  output logic [ADDR_WIDTH:0] count,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full,
  output logic                pause,
  output logic                continua,
  output logic                err_overflow,
  output logic                err_underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned WW    = BUS_SIZE + 1;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_almost_empty;
  logic                  r_almost_full;
  logic                  r_rd_fire;
  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic [WW-1:0]         w_rd_word;
  flow_state_e           r_state;
  flow_state_e           w_state_nxt;

  // Acceptance, next occupancy and next flow-control state.
  always_comb begin
    w_push_acc  = push && (!r_full || pop);
    w_pop_acc   = pop && !r_empty;
    w_count_nxt = r_count;
    w_state_nxt = r_state;

    if (w_push_acc && !w_pop_acc) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push_acc && w_pop_acc) begin
      w_count_nxt = r_count - CW'(1);
    end

    // Hysteresis: thresholds are looked up against the post-edge occupancy.
    case (r_state)
      FLOW_GO: begin
        if (w_count_nxt >= CW'(ALMOST_FULL_TH)) begin
          w_state_nxt = FLOW_PAUSE;
        end
      end
      FLOW_PAUSE: begin
        if (w_count_nxt <= CW'(ALMOST_EMPTY_TH)) begin
          w_state_nxt = FLOW_GO;
        end
      end
      default: w_state_nxt = FLOW_GO;
    endcase
  end

  // Flow-control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FLOW_GO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pointers, occupancy and flags; flags are registered from the next count
  // so they line up with r_count without a path from push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_rd_fire      <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_count        <= w_count_nxt;
      r_empty        <= (w_count_nxt == '0);
      r_full         <= (w_count_nxt == CW'(DEPTH));
      r_almost_empty <= (w_count_nxt <= CW'(ALMOST_EMPTY_TH));
      r_almost_full  <= (w_count_nxt >= CW'(ALMOST_FULL_TH));
      r_rd_fire      <= w_pop_acc;
    end
  end

  // Reset outranks a same-cycle push, so the array is not written then.
  fifo_ram #(
    .WIDTH (WW),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_push_acc && !reset),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({valid, data_in}),
    .i_rd_en   (w_pop_acc && !reset),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_word)
  );

`ifdef FIFO_PARAM_ERR_EN
  logic r_err_overflow;
  logic r_err_underflow;

  // Sticky error capture; requests are judged against the pre-edge state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (push && r_full && !pop) begin
        r_err_overflow <= 1'b1;
      end
      if (pop && r_empty) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

  // The stored tag is only presented in the cycle after an accepted pop.
  assign data_out     = w_rd_word[BUS_SIZE-1:0];
  assign valid_out    = w_rd_word[BUS_SIZE] & r_rd_fire;
  assign count        = r_count;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign pause        = (r_state == FLOW_PAUSE);
  assign continua     = (r_state == FLOW_GO);

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations along the directed test.
module tb_fifo_param;

  localparam int BS    = 10;
  localparam int AW    = 3;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int DEPTH = 8;
`ifdef FIFO_PARAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          valid = 1'b0;
  logic [BS-1:0] data_in = '0;
  logic [BS-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   count;
  logic          empty, full, almost_empty, almost_full;
  logic          pause, continua, err_overflow, err_underflow;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [BS:0]   mq[$];
  logic [BS-1:0] m_dout = '0;
  logic          m_vout = 1'b0;
  logic          m_pause = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  fifo_param #(
    .BUS_SIZE        (BS),
    .ADDR_WIDTH      (AW),
    .ALMOST_FULL_TH  (AF),
    .ALMOST_EMPTY_TH (AE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .pop           (pop),
    .valid         (valid),
    .data_in       (data_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .almost_empty  (almost_empty),
    .almost_full   (almost_full),
    .pause         (pause),
    .continua      (continua),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue semantics applied at each rising edge.
  initial begin
    logic [BS:0] w;
    logic        do_pop, do_push;
    int          n;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        m_dout  = '0;
        m_vout  = 1'b0;
        m_pause = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
      end else begin
        n       = mq.size();
        m_vout  = 1'b0;
        do_pop  = pop && (n != 0);
        do_push = push && ((n < DEPTH) || do_pop);
        if (push && (n == DEPTH) && !pop) m_ovf = 1'b1;
        if (pop && (n == 0)) m_udf = 1'b1;
        if (do_pop) begin
          w      = mq.pop_front();
          m_vout = w[BS];
          m_dout = w[BS-1:0];
        end
        if (do_push) mq.push_back({valid, data_in});
        n = mq.size();
        if (n >= AF) m_pause = 1'b1;
        else if (n <= AE) m_pause = 1'b0;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    int n;
    forever begin
      @(negedge clk);
      n = mq.size();
      chk("count",         32'(count),         32'(n));
      chk("empty",         32'(empty),         32'(n == 0));
      chk("full",          32'(full),          32'(n == DEPTH));
      chk("almost_empty",  32'(almost_empty),  32'(n <= AE));
      chk("almost_full",   32'(almost_full),   32'(n >= AF));
      chk("pause",         32'(pause),         32'(m_pause));
      chk("continua",      32'(continua),      32'(!m_pause));
      chk("data_out",      32'(data_out),      32'(m_dout));
      chk("valid_out",     32'(valid_out),     32'(m_vout));
      chk("err_overflow",  32'(err_overflow),  32'(ERR_EN & m_ovf));
      chk("err_underflow", 32'(err_underflow), 32'(ERR_EN & m_udf));
    end
  end

  // One clock of stimulus; returns on the following falling edge.
  task automatic step(input logic pu, input logic po, input logic va, input logic [BS-1:0] d);
    push    = pu;
    pop     = po;
    valid   = va;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    logic [BS-1:0] d;
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 10'h155);
    reset = 1'b0;
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_aempty",   32'(almost_empty), 32'd1);
    chk("rst_pause",    32'(pause),    32'd0);
    chk("rst_continua", 32'(continua), 32'd1);

    // Pop while empty.
    step(1'b0, 1'b1, 1'b0, '0);
    chk("udf_count",  32'(count),         32'd0);
    chk("udf_vout",   32'(valid_out),     32'd0);
    chk("udf_dout",   32'(data_out),      32'd0);
    chk("udf_flag",   32'(err_underflow), 32'(ERR_EN));

    // Fill to full, watching pause rise on the 6th push.
    for (int i = 1; i <= DEPTH; i++) begin
      d = BS'(i);
      step(1'b1, 1'b0, 1'b1, d);
      chk("fill_pause", 32'(pause), 32'(i >= 6));
    end
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full",  32'(full),  32'd1);

    // Push while full is dropped.
    step(1'b1, 1'b0, 1'b1, 10'h3FF);
    chk("ovf_count", 32'(count),        32'd8);
    chk("ovf_flag",  32'(err_overflow), 32'(ERR_EN));

    // Drain in order; pause holds until occupancy falls to 2.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      chk("drain_dout",  32'(data_out),  32'(i));
      chk("drain_vout",  32'(valid_out), 32'd1);
      chk("drain_pause", 32'(pause),     32'((DEPTH - i) > 2));
    end
    step(1'b0, 1'b0, 1'b0, '0);
    chk("drain_vout_idle", 32'(valid_out), 32'd0);
    chk("drain_dout_hold", 32'(data_out),  32'd8);

    // Push 5 / pop 5, three rounds, wrapping the pointers.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        d = BS'(32'h100 + r * 5 + i);
        step(1'b1, 1'b0, 1'b1, d);
      end
      for (int i = 0; i < 5; i++) begin
        step(1'b0, 1'b1, 1'b0, '0);
        chk("wrap_dout", 32'(data_out), 32'h100 + 32'(r * 5 + i));
      end
      chk("wrap_count", 32'(count), 32'd0);
    end

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) begin
      d = BS'(32'h200 + i);
      step(1'b1, 1'b0, 1'b1, d);
    end
    step(1'b1, 1'b1, 1'b1, 10'h2AA);
    chk("fullpp_count", 32'(count),    32'd8);
    chk("fullpp_dout",  32'(data_out), 32'h200);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      if (i < DEPTH) chk("fullpp_drain", 32'(data_out), 32'h200 + 32'(i));
      else           chk("fullpp_new",   32'(data_out), 32'h2AA);
    end

    // Empty FIFO with simultaneous push and pop: no bypass.
    step(1'b1, 1'b1, 1'b1, 10'h055);
    chk("emptypp_count", 32'(count),     32'd1);
    chk("emptypp_vout",  32'(valid_out), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("emptypp_dout",  32'(data_out),  32'h055);

    // Alternating valid tags.
    for (int i = 0; i < 4; i++) begin
      d = BS'(32'h300 + i);
      step(1'b1, 1'b0, ((i % 2) == 0), d);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      chk("tag_vout", 32'(valid_out), 32'((i % 2) == 0));
      chk("tag_dout", 32'(data_out),  32'h300 + 32'(i));
    end

    // Reach count=4 while paused, then reset mid-stream.
    for (int i = 0; i < 6; i++) begin
      d = BS'(32'h010 + i);
      step(1'b1, 1'b0, 1'b1, d);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("mid_count", 32'(count), 32'd4);
    chk("mid_pause", 32'(pause), 32'd1);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b1, 10'h0AA);
    reset = 1'b0;
    chk("mrst_count", 32'(count),        32'd0);
    chk("mrst_pause", 32'(pause),        32'd0);
    chk("mrst_empty", 32'(empty),        32'd1);
    chk("mrst_ovf",   32'(err_overflow), 32'd0);
    step(1'b0, 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
